// File: rtl/serial_add_minus_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
//   state_e      : control FSM states
//   calc_ndig    : number of digits per operand (WIDTH/DIGIT)
//   calc_cnt_w   : width of the digit counter, never below one bit
package serial_add_minus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_add_minus_if.sv
// Operand/result handshake bundle for serial_add_minus.
//   master : operand producer / result consumer (drives in_valid, a, b, m, acc, out_ready)
//   slave  : the adder itself (drives in_ready, out_valid, s and the flags c, v, z, n)
interface serial_add_minus_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
    logic             n;

    modport master (
        output in_valid, a, b, m, acc, out_ready,
        input  in_ready, out_valid, s, c, v, z, n
    );

    modport slave (
        input  in_valid, a, b, m, acc, out_ready,
        output in_ready, out_valid, s, c, v, z, n
    );
endinterface

// File: rtl/serial_add_minus_addsub_digit.sv
// Combinational DIGIT-wide ripple adder built from one-bit full adders.
//   add          : a_i, b_i, cin_i -> s_o, cout_o (single-bit full adder)
//   addsub_digit : a_i, b_i [DIGIT], cin_i -> sum_o [DIGIT], cout_o,
//                  c_msb_o (carry into the top bit, used for signed overflow)
module add (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);
    logic [DIGIT:0] cy;

    assign cy[0] = cin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        add u_add (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .cin_i  (cy[i]),
            .s_o    (sum_o[i]),
            .cout_o (cy[i+1])
        );
    end

    assign cout_o  = cy[DIGIT];
    assign c_msb_o = cy[DIGIT-1];
endmodule

// File: rtl/serial_add_minus.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock,
// LSB digit first. An operation takes NDIG = WIDTH/DIGIT RUN cycles.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of serial_add_minus_if (operands in, result + flags out)
// The accumulator captures each result on its output handshake and may
// replace operand A (acc=1) for chained add/sub sequences.
module serial_add_minus
    import serial_add_minus_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_minus_if.slave   bus
);
    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = calc_cnt_w(NDIG);

    state_e           state_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, v_q, z_q, n_q;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout, dig_cmsb;
    logic             last_dig;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i     (opa_q[DIGIT-1:0]),
        .b_i     (opb_q[DIGIT-1:0]),
        .cin_i   (carry_q),
        .sum_o   (dig_sum),
        .cout_o  (dig_cout),
        .c_msb_o (dig_cmsb)
    );

    // Sum digits enter from the top so after NDIG shifts the LSB digit
    // has arrived at bit 0. With a single digit there is nothing to shift.
    if (NDIG == 1) begin : g_one
        assign res_d = dig_sum;
    end else begin : g_multi
        assign res_d = {dig_sum, res_q[WIDTH-1:DIGIT]};
    end

    assign last_dig = (cnt_q == CW'(NDIG - 1));

    // On the last digit dig_cmsb is the carry into bit WIDTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa_q   <= bus.acc ? acc_q : bus.a;
                        opb_q   <= bus.b ^ {WIDTH{bus.m}};
                        carry_q <= bus.m;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    opa_q   <= opa_q >> DIGIT;
                    opb_q   <= opb_q >> DIGIT;
                    carry_q <= dig_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_dig) begin
                        s_q     <= res_d;
                        c_q     <= dig_cout;
                        v_q     <= dig_cmsb ^ dig_cout;
                        z_q     <= (res_d == '0);
                        n_q     <= res_d[WIDTH-1];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        acc_q   <= s_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
endmodule

// File: tb/tb_serial_add_minus.sv
// Directed bench: a 16/4 instance driven from a vector table plus hand
// sequences (backpressure, accumulator chaining, mid-run reset), and an
// 8/8 instance for the single-digit case.
module tb_serial_add_minus;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_minus_if #(.WIDTH(16)) if16 ();
    serial_add_minus_if #(.WIDTH(8))  if8  ();

    serial_add_minus #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    serial_add_minus #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst(rst), .bus(if8));

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        acc;
        logic [15:0] s;
        logic        c, v, z, n;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Launch an operation on the 16-bit DUT and wait for out_valid.
    // Latency is counted in rising edges after the accept edge: NDIG=4,
    // so out_valid appears in the 5th cycle counting the accept cycle.
    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic m, input logic acc, input string tag);
        int  lat;
        bit  rdy_seen;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(if16.in_ready), 32'd1);
        if16.a = a; if16.b = b; if16.m = m; if16.acc = acc; if16.in_valid = 1'b1;
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        while (!if16.out_valid && lat < 20) begin
            if (if16.in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " in_ready low in run"}, 32'(rdy_seen), 32'd0);
    endtask

    task automatic check_res16(input vec_t t, input string tag);
        @(negedge clk);
        check({tag, " s"}, 32'(if16.s), 32'(t.s));
        check({tag, " flags cvzn"}, 32'({if16.c, if16.v, if16.z, if16.n}),
              32'({t.c, t.v, t.z, t.n}));
    endtask

    task automatic release16(input string tag);
        @(negedge clk);
        if16.out_ready = 1'b1;
        @(posedge clk);
        #1 if16.out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(if16.out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(if16.in_ready), 32'd1);
    endtask

    vec_t tbl [4];
    vec_t tv;

    initial begin
        if16.in_valid = 0; if16.a = 0; if16.b = 0; if16.m = 0; if16.acc = 0; if16.out_ready = 0;
        if8.in_valid  = 0; if8.a  = 0; if8.b  = 0; if8.m  = 0; if8.acc  = 0; if8.out_ready  = 0;

        //              a        b        m     acc   s        c     v     z     n
        tbl[0] = '{16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(if16.in_ready), 32'd0);
        check("rst out_valid", 32'(if16.out_valid), 32'd0);
        check("rst s", 32'(if16.s), 32'd0);
        check("rst flags", 32'({if16.c, if16.v, if16.z, if16.n}), 32'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 4; i++) begin
            issue16(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].acc, $sformatf("vec%0d", i));
            check_res16(tbl[i], $sformatf("vec%0d", i));
            release16($sformatf("vec%0d", i));
        end

        // 0 - 1 with backpressure: result must hold, in_valid ignored
        tv = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        issue16(tv.a, tv.b, tv.m, tv.acc, "hold");
        check_res16(tv, "hold");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if16.a = 16'h5555; if16.b = 16'h1111; if16.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d s", k), 32'(if16.s), 32'hFFFF);
            check($sformatf("hold%0d flags", k), 32'({if16.c, if16.v, if16.z, if16.n}), 32'b0001);
            check($sformatf("hold%0d out_valid", k), 32'(if16.out_valid), 32'd1);
            check($sformatf("hold%0d in_ready", k), 32'(if16.in_ready), 32'd0);
        end
        @(negedge clk);
        if16.in_valid = 1'b0;
        release16("hold");

        // Accumulator (0xFFFF) + 2
        tv = '{16'h0000, 16'h0002, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        issue16(16'hAAAA, tv.b, tv.m, tv.acc, "acc");
        check_res16(tv, "acc");
        release16("acc");

        // Reset in the 2nd RUN cycle abandons the op and clears the accumulator
        @(negedge clk);
        if16.a = 16'h0F0F; if16.b = 16'h0101; if16.m = 1'b0; if16.acc = 1'b0; if16.in_valid = 1'b1;
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst out_valid", 32'(if16.out_valid), 32'd0);
        check("midrst in_ready", 32'(if16.in_ready), 32'd1);
        check("midrst s", 32'(if16.s), 32'd0);
        tv = '{16'h0000, 16'h0007, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
        issue16(16'h1234, tv.b, tv.m, tv.acc, "postrst");
        check_res16(tv, "postrst");
        release16("postrst");

        // Single-digit instance: 0x80 + 0x80, latency one edge after accept
        begin
            int lat8;
            @(negedge clk);
            check("w8 in_ready", 32'(if8.in_ready), 32'd1);
            if8.a = 8'h80; if8.b = 8'h80; if8.m = 1'b0; if8.acc = 1'b0; if8.in_valid = 1'b1;
            @(posedge clk);
            #1 if8.in_valid = 1'b0;
            lat8 = 0;
            while (!if8.out_valid && lat8 < 10) begin
                @(posedge clk);
                #1 lat8++;
            end
            check("w8 latency", 32'(lat8), 32'd1);
            check("w8 s", 32'(if8.s), 32'h00);
            check("w8 flags cvzn", 32'({if8.c, if8.v, if8.z, if8.n}), 32'b1110);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got stuck, expected completion");
        $fatal(1);
    end

endmodule
